// File: rtl/speed_ctrl_pkg.sv
// speed_ctrl_pkg: shared FSM states, direction codes and timer sizing for speed_ctrl_fsm
package speed_ctrl_pkg;
   typedef enum logic [1:0] {S_IDLE, S_HELD, S_REPEAT, S_LOCK} state_t;
   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DOWN = 1'b1;
   function automatic int tmr_w(input int h, input int r, input int d);
      int m;
      m = h > r ? h : r;
      m = m > d ? m : d;
      return $clog2(m + 1);
   endfunction
endpackage

// File: rtl/key_conditioner.sv
// key_conditioner: 2-FF synchroniser, debouncer and press-edge detector for one raw key
module key_conditioner
   import speed_ctrl_pkg::*;
#(
   parameter int DEBOUNCE = 4
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic KEY_RAW,
   output logic LEVEL,
   output logic PRESS
);
   localparam int CW = tmr_w(1, 1, DEBOUNCE);
   logic [1:0] sync;
   logic [CW-1:0] cnt;
   logic level_q;
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         sync    <= '0;
         cnt     <= '0;
         LEVEL   <= 1'b0;
         level_q <= 1'b0;
      end else begin
         sync    <= {sync[0], KEY_RAW};
         level_q <= LEVEL;
         if (sync[1] == LEVEL)
            cnt <= '0;
         else if (cnt == CW'(DEBOUNCE)) begin
            LEVEL <= sync[1];
            cnt   <= '0;
         end else
            cnt <= cnt + CW'(1);
      end
   end
   assign PRESS = LEVEL & ~level_q;
endmodule

// File: rtl/speed_ctrl_fsm.sv
// speed_ctrl_fsm: two-key speed controller with auto-repeat steps and a saturating speed register
module speed_ctrl_fsm
   import speed_ctrl_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int SPEED_MIN  = 0,
   parameter int SPEED_MAX  = 15,
   parameter int SPEED_INIT = 0,
   parameter int DEBOUNCE   = 4,
   parameter int HOLD       = 8,
   parameter int REPEAT     = 4
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             Key1,
   input  logic             Key2,
   output logic             ENABLE,
   output logic             UP_DOWN,
   output logic [WIDTH-1:0] SPEED,
   output logic             AT_MIN,
   output logic             AT_MAX
);
   localparam int TW = tmr_w(HOLD, REPEAT, DEBOUNCE);
   state_t state;
   logic [TW-1:0] timer;
   logic dir;
   logic lvl1, lvl2, prs1, prs2;
   logic act_lvl, oth_prs, new_dir, tmr_done, step_ok, step_req;
   key_conditioner #(.DEBOUNCE(DEBOUNCE)) u_key1 (
      .CLK(CLK), .RSTn(RSTn), .KEY_RAW(Key1), .LEVEL(lvl1), .PRESS(prs1)
   );
   key_conditioner #(.DEBOUNCE(DEBOUNCE)) u_key2 (
      .CLK(CLK), .RSTn(RSTn), .KEY_RAW(Key2), .LEVEL(lvl2), .PRESS(prs2)
   );
   always_comb begin
      act_lvl  = dir ? lvl1 : lvl2;
      oth_prs  = dir ? prs2 : prs1;
      new_dir  = (state == S_IDLE) ? prs1 : dir;
      tmr_done = timer == TW'(1);
      step_ok  = new_dir ? (SPEED > WIDTH'(SPEED_MIN)) : (SPEED < WIDTH'(SPEED_MAX));
      step_req = (state == S_IDLE) ? (prs1 != prs2)
               : (state == S_HELD || state == S_REPEAT) ? (act_lvl && !oth_prs && tmr_done)
               : 1'b0;
   end
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state   <= S_IDLE;
         timer   <= '0;
         dir     <= DIR_UP;
         ENABLE  <= 1'b0;
         UP_DOWN <= DIR_UP;
         SPEED   <= WIDTH'(SPEED_INIT);
      end else begin
         ENABLE <= 1'b0;
         if (step_req && step_ok) begin
            ENABLE  <= 1'b1;
            UP_DOWN <= new_dir;
            SPEED   <= new_dir ? SPEED - WIDTH'(1) : SPEED + WIDTH'(1);
         end
         case (state)
            S_IDLE:
               if (prs1 && prs2)
                  state <= S_LOCK;
               else if (prs1 || prs2) begin
                  state <= S_HELD;
                  dir   <= prs1;
                  timer <= TW'(HOLD);
               end
            S_HELD, S_REPEAT:
               if (!act_lvl)
                  state <= S_IDLE;
               else if (oth_prs)
                  state <= S_LOCK;
               else if (tmr_done) begin
                  state <= S_REPEAT;
                  timer <= TW'(REPEAT);
               end else
                  timer <= timer - TW'(1);
            S_LOCK:
               if (!lvl1 && !lvl2)
                  state <= S_IDLE;
            default:
               state <= S_IDLE;
         endcase
      end
   end
   assign AT_MIN = SPEED == WIDTH'(SPEED_MIN);
   assign AT_MAX = SPEED == WIDTH'(SPEED_MAX);
endmodule

// File: tb/tb_speed_ctrl_fsm.sv
// tb_speed_ctrl_fsm: directed checks of press latency, auto-repeat, debounce, lockout, saturation and reset
module tb_speed_ctrl_fsm;
   logic CLK = 1'b0;
   logic RSTn = 1'b0;
   logic Key1 = 1'b0;
   logic Key2 = 1'b0;
   logic en_d, ud_d, min_d, max_d, en_s, ud_s, min_s, max_s;
   logic [3:0] spd_d, spd_s;
   int n_vec = 0;
   int n_err = 0;
   int m_spd [2];
   always #5 CLK = ~CLK;
   speed_ctrl_fsm u_dut (
      .CLK(CLK), .RSTn(RSTn), .Key1(Key1), .Key2(Key2),
      .ENABLE(en_d), .UP_DOWN(ud_d), .SPEED(spd_d), .AT_MIN(min_d), .AT_MAX(max_d)
   );
   speed_ctrl_fsm #(.SPEED_INIT(15)) u_sat (
      .CLK(CLK), .RSTn(RSTn), .Key1(Key1), .Key2(Key2),
      .ENABLE(en_s), .UP_DOWN(ud_s), .SPEED(spd_s), .AT_MIN(min_s), .AT_MAX(max_s)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic do_reset();
      RSTn = 1'b0;
      Key1 = 1'b0;
      Key2 = 1'b0;
      tick();
      tick();
      RSTn = 1'b1;
      m_spd[0] = 0;
      m_spd[1] = 15;
   endtask
   // n counts edges from the first one that samples the key; HOLD=8, REPEAT=4, DEBOUNCE=4
   task automatic press(input bit sat, input bit dn, input int hold, input int len);
      bit sched, exp_en;
      if (dn) Key1 = 1'b1; else Key2 = 1'b1;
      for (int n = 1; n <= len; n++) begin
         tick();
         sched  = (n <= hold + 7) && (n == 8 || (n >= 16 && n % 4 == 0));
         exp_en = sched && (dn ? m_spd[sat] > 0 : m_spd[sat] < 15);
         if (exp_en) m_spd[sat] += dn ? -1 : 1;
         check($sformatf("enable n=%0d", n), sat ? en_s : en_d, exp_en);
         check($sformatf("speed n=%0d", n), sat ? spd_s : spd_d, m_spd[sat]);
         if (exp_en) check($sformatf("up_down n=%0d", n), sat ? ud_s : ud_d, dn);
         if (n == hold) begin
            if (dn) Key1 = 1'b0; else Key2 = 1'b0;
         end
      end
   endtask
   initial begin
      do_reset();
      check("rst speed", spd_d, 0);
      check("rst enable", en_d, 0);
      check("rst up_down", ud_d, 0);
      check("rst at_min", min_d, 1);
      check("rst at_max", max_d, 0);
      check("rst sat speed", spd_s, 15);
      check("rst sat at_max", max_s, 1);
      check("rst sat at_min", min_s, 0);
      Key2 = 1'b1;
      repeat (3) tick();
      Key2 = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         check("short enable", en_d, 0);
      end
      check("short speed", spd_d, 0);
      press(0, 0, 40, 50);
      check("repeat speed", spd_d, 9);
      for (int i = 0; i < 20; i++) begin
         Key1 = (i % 4) < 2;
         tick();
         check("bounce enable", en_d, 0);
      end
      press(0, 1, 8, 25);
      check("bounce speed", spd_d, 8);
      Key1 = 1'b1;
      Key2 = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         check("both enable", en_d, 0);
      end
      Key2 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("lock enable", en_d, 0);
      end
      Key1 = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         check("unlock enable", en_d, 0);
      end
      check("lock speed", spd_d, 8);
      press(0, 1, 8, 25);
      check("post-lock speed", spd_d, 7);
      do_reset();
      press(0, 0, 1000, 28);
      check("pre-reset speed", spd_d, 5);
      RSTn = 1'b0;
      tick();
      check("mid-reset speed", spd_d, 0);
      check("mid-reset enable", en_d, 0);
      check("mid-reset at_min", min_d, 1);
      RSTn = 1'b1;
      m_spd[0] = 0;
      press(0, 0, 8, 25);
      check("post-reset speed", spd_d, 1);
      do_reset();
      press(1, 0, 40, 50);
      check("sat speed", spd_s, 15);
      check("sat at_max", max_s, 1);
      press(1, 1, 8, 25);
      check("sat dec speed", spd_s, 14);
      check("sat dec at_max", max_s, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
